// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
// DEFAULT_CLKS_PER_BIT and DATA_BITS are common to the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: the serial line in, and the byte/status outputs to uart_mmio.
// The receiver uses the master modport; the consumer uses the slave modport.
interface uart_rx_if
  import uart_pkg::*;
  ();

  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_valid;
  logic                 rx_framing_error;
  logic                 rx_busy;

  modport master (
    input  rx_in,
    output rx_data,
    output rx_data_valid,
    output rx_framing_error,
    output rx_busy
  );

  modport slave (
    output rx_in,
    input  rx_data,
    input  rx_data_valid,
    input  rx_framing_error,
    input  rx_busy
  );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Latency STAGES cycles; rst_val picks the value the chain holds during reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("uart_sync: STAGES must be >= 2");
    end
  endgenerate

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff <= {STAGES{rst_val}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: samples each bit once at its centre and emits one-cycle
// valid or framing-error pulses. No buffering; the consumer must take rx_data on valid.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master bus
);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 busy_q;

  // Line idles high, so the chain resets high to avoid a false start on release.
  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .rst_val (1'b1),
    .d       (bus.rx_in),
    .q       (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets an immediately following start edge be caught.
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              rx_data_q <= shift;
              valid_q   <= 1'b1;
              state     <= IDLE;
              busy_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
              state <= WAIT_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data          = rx_data_q;
  assign bus.rx_data_valid    = valid_q;
  assign bus.rx_framing_error = err_q;
  assign bus.rx_busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed and random frames checked
// against a frame-level model (good stop -> byte expected, bad stop -> one error).
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  int         start_q[$];

  // Observed behaviour
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         got_err = 0;
  int         both_hi = 0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_data_valid) begin
        got_q.push_back(bus.rx_data);
        got_cyc.push_back(cyc);
      end
      if (bus.rx_framing_error) got_err++;
      if (bus.rx_data_valid && bus.rx_framing_error) both_hi++;
      if (bus.rx_busy) busy_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.rx_in = 1'b0;
    start_q.push_back(cyc);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = b[i];
      tick(CPB);
    end
    bus.rx_in = stop_bit;
    tick(CPB);
    bus.rx_in = 1'b1;
    if (stop_bit) exp_q.push_back(b);
    else exp_err++;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    check({tag, "_errs"}, got_err, exp_err);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       stop_bit;
    int         lat;
    int         gap;

    reset     = 1'b1;
    bus.rx_in = 1'b1;
    tick(3);
    check("reset_data", bus.rx_data, 8'h00);
    check("reset_valid", bus.rx_data_valid, 1'b0);
    check("reset_err", bus.rx_framing_error, 1'b0);
    check("reset_busy", bus.rx_busy, 1'b0);
    reset = 1'b0;
    tick(5);

    // 1: single frame with latency measurement
    send_frame(8'h55, 1'b1);
    tick(CPB);
    lat = (got_cyc.size() > 0) ? got_cyc[0] - start_q[0] : -1;
    check("t1_latency_window", (lat >= 154 && lat <= 156), 1'b1);
    check("t1_data", bus.rx_data, 8'h55);
    check_rx("t1");

    // 2: back-to-back frames, no idle gap
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(2 * CPB);
    check("t2_spacing", (got_cyc.size() == 2) ? got_cyc[1] - got_cyc[0] : -1, 160);
    check_rx("t2");

    // 3: short glitch is a false start
    busy_cnt  = 0;
    bus.rx_in = 1'b0;
    tick(4);
    bus.rx_in = 1'b1;
    tick(30);
    check("t3_busy_short", (busy_cnt > 0 && busy_cnt < 12), 1'b1);
    check("t3_idle", bus.rx_busy, 1'b0);
    check_rx("t3");

    // 4: good frame then a bad stop bit
    send_frame(8'h12, 1'b1);
    send_frame(8'hFF, 1'b0);
    tick(3 * CPB);
    check("t4_data_held", bus.rx_data, 8'h12);
    check_rx("t4");

    // 5: long break gives exactly one framing error
    bus.rx_in = 1'b0;
    tick(40 * CPB);
    bus.rx_in = 1'b1;
    exp_err++;
    tick(2 * CPB);
    send_frame(8'h81, 1'b1);
    tick(2 * CPB);
    check("t5_data", bus.rx_data, 8'h81);
    check_rx("t5");

    // Random frames with occasional bad stop bits and random gaps
    for (int n = 0; n < 8; n++) begin
      b        = 8'($urandom);
      stop_bit = ($urandom_range(0, 4) != 0);
      send_frame(b, stop_bit);
      gap = $urandom_range(0, 20);
      if (!stop_bit) gap += CPB;
      tick(gap);
    end
    tick(2 * CPB);
    check_rx("rand");

    // 6: reset during data bit 4 abandons the frame
    b         = 8'h5A;
    bus.rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rx_in = b[i];
      tick(CPB);
    end
    bus.rx_in = b[4];
    tick(CPB / 2);
    reset     = 1'b1;
    bus.rx_in = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3 * CPB);
    check("t6_data_cleared", bus.rx_data, 8'h00);
    check("t6_busy", bus.rx_busy, 1'b0);
    check_rx("t6_abort");
    send_frame(8'h7E, 1'b1);
    tick(2 * CPB);
    check("t6_data", bus.rx_data, 8'h7E);
    check_rx("t6");

    check("never_both_pulses", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
